// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and types for the multi-channel PWM generator.
// Latency: n/a (declarations only). Backpressure: n/a.
// Contents: default WIDTH/CHANNELS, count-direction enum (used by center-aligned build, PWM_CENTER_EN).
package pwm_pkg;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_CHANNELS = 2;

  // Direction of the center-aligned up/down counter.
  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } cnt_dir_e;

endpackage

// File: rtl/pwm_chan.sv
// pwm_chan: one PWM compare channel with double-buffered (shadow/active) duty.
// Latency: one cycle from cnt to pwm_sig; pending sets the cycle after duty_wr.
// Backpressure: none, duty_wr is always accepted; last write before a transfer wins.
//
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   cnt         - shared period counter value
//   load_tick   - transfer shadow->active this cycle if pending
//   en          - global run enable (gates the output)
//   duty        - duty value for this channel
//   duty_wr     - write strobe, captures duty into shadow
//   pwm_sig     - registered PWM output
//   pending     - shadow holds a value not yet transferred to active
module pwm_chan
  import pwm_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cnt,
  input  logic             load_tick,
  input  logic             en,
  input  logic [WIDTH-1:0] duty,
  input  logic             duty_wr,
  output logic             pwm_sig,
  output logic             pending
);

  logic [WIDTH-1:0] shadow;
  logic [WIDTH-1:0] active;

  // Transfer is evaluated before the write so a write landing on the
  // transfer cycle leaves the new value pending for the following period,
  // while active picks up the value the shadow held before the write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow  <= '0;
      active  <= '0;
      pending <= 1'b0;
    end else begin
      if (load_tick && pending) begin
        active  <= shadow;
        pending <= 1'b0;
      end
      if (duty_wr) begin
        shadow  <= duty;
        pending <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_sig <= 1'b0;
    end else begin
      pwm_sig <= en & (cnt < active);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// pwm_multi: shared-counter multi-channel PWM generator with glitch-free duty updates.
// Latency: one cycle from counter to pwm_sig/period_start; duty applies from the next period.
// Backpressure: none, duty_wr strobes are always accepted.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   en            - global run enable; counter held at 0 and outputs low while 0
//   duty          - flattened duties, channel i at duty[i*WIDTH +: WIDTH]
//   duty_wr       - per-channel shadow write strobe
//   pwm_sig       - registered PWM outputs
//   pending       - per-channel shadow-not-yet-active flag
//   period_start  - one-cycle pulse on the first output cycle of each period
//
// Build option: define PWM_CENTER_EN for a center-aligned (up/down) counter
// with period 2*(2^WIDTH-1); otherwise an edge-aligned sawtooth of 2^WIDTH.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int CHANNELS = DEF_CHANNELS
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      en,
  input  logic [CHANNELS*WIDTH-1:0] duty,
  input  logic [CHANNELS-1:0]       duty_wr,
  output logic [CHANNELS-1:0]       pwm_sig,
  output logic [CHANNELS-1:0]       pending,
  output logic                      period_start
);

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [WIDTH-1:0] cnt;
  logic [WIDTH-1:0] cnt_nxt;
  logic             load_tick;

`ifdef PWM_CENTER_EN
  localparam logic [WIDTH-1:0] CNT_ONE = 1;

  cnt_dir_e dir;
  cnt_dir_e dir_nxt;

  // Up 0..MAX, then down MAX-1..1, back to 0 counting up (the valley).
  always_comb begin
    cnt_nxt = '0;
    dir_nxt = UP;
    if (en) begin
      dir_nxt = dir;
      if (dir == UP) begin
        if (cnt == CNT_MAX) begin
          cnt_nxt = CNT_MAX - 1'b1;
          dir_nxt = DOWN;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end else begin
        if (cnt == CNT_ONE) begin
          cnt_nxt = '0;
          dir_nxt = UP;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir <= UP;
    end else begin
      dir <= dir_nxt;
    end
  end

  // While disabled, transfer every cycle so enabling starts with the latest duties.
  assign load_tick = !en || ((cnt == '0) && (dir == UP));
`else
  always_comb begin
    cnt_nxt = '0;
    if (en) begin
      cnt_nxt = cnt + 1'b1;
    end
  end

  // While disabled, transfer every cycle so enabling starts with the latest duties.
  assign load_tick = !en || (cnt == CNT_MAX);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt          <= '0;
      period_start <= 1'b0;
    end else begin
      cnt          <= cnt_nxt;
      period_start <= en & (cnt == '0);
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    pwm_chan #(
      .WIDTH(WIDTH)
    ) u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .cnt      (cnt),
      .load_tick(load_tick),
      .en       (en),
      .duty     (duty[i*WIDTH +: WIDTH]),
      .duty_wr  (duty_wr[i]),
      .pwm_sig  (pwm_sig[i]),
      .pending  (pending[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// tb_pwm_multi: self-checking bench for pwm_multi (WIDTH=8, CHANNELS=2).
// A cycle-level reference steps alongside the DUT; per-cycle expectations are
// queued when stimulus is applied and popped when the DUT output is sampled.
module tb_pwm_multi;

  localparam int W   = 8;
  localparam int CH  = 2;
  localparam int MAX = 255;
`ifdef PWM_CENTER_EN
  localparam int PERIOD = 510;
`else
  localparam int PERIOD = 256;
`endif

  logic            clk;
  logic            rst_n;
  logic            en;
  logic [CH*W-1:0] duty;
  logic [CH-1:0]   duty_wr;
  logic [CH-1:0]   pwm_sig;
  logic [CH-1:0]   pending;
  logic            period_start;

  pwm_multi #(.WIDTH(W), .CHANNELS(CH)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .duty        (duty),
    .duty_wr     (duty_wr),
    .pwm_sig     (pwm_sig),
    .pending     (pending),
    .period_start(period_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference state
  int          m_cnt;
  bit          m_down;
  logic [W-1:0] m_sh [CH];
  logic [W-1:0] m_act[CH];
  logic [CH-1:0] m_pend;
  logic [2*CH:0] exp_q[$];
  int hi0, hi1, ps_n;

  task automatic model_reset();
    m_cnt  = 0;
    m_down = 1'b0;
    m_pend = '0;
    for (int i = 0; i < CH; i++) begin
      m_sh[i]  = '0;
      m_act[i] = '0;
    end
    exp_q.delete();
  endtask

  // Advance one clock: queue expected outputs for this edge, then sample.
  task automatic step();
    logic [CH-1:0] e_pwm;
    logic          e_ps;
    logic          load;
    logic [2*CH:0] got;
    logic [2*CH:0] exp;
    e_ps = en && (m_cnt == 0);
    for (int i = 0; i < CH; i++) e_pwm[i] = en && (m_cnt < int'(m_act[i]));
`ifdef PWM_CENTER_EN
    load = !en || (m_cnt == 0 && !m_down);
`else
    load = !en || (m_cnt == MAX);
`endif
    for (int i = 0; i < CH; i++) begin
      if (load && m_pend[i]) begin
        m_act[i]  = m_sh[i];
        m_pend[i] = 1'b0;
      end
      if (duty_wr[i]) begin
        m_sh[i]   = duty[i*W +: W];
        m_pend[i] = 1'b1;
      end
    end
`ifdef PWM_CENTER_EN
    if (!en) begin
      m_cnt = 0; m_down = 1'b0;
    end else if (!m_down) begin
      if (m_cnt == MAX) begin m_cnt = MAX - 1; m_down = 1'b1; end
      else m_cnt = m_cnt + 1;
    end else begin
      if (m_cnt == 1) begin m_cnt = 0; m_down = 1'b0; end
      else m_cnt = m_cnt - 1;
    end
`else
    m_cnt = en ? (m_cnt + 1) % 256 : 0;
`endif
    exp_q.push_back({e_ps, m_pend, e_pwm});
    @(posedge clk);
    #1;
    duty_wr = '0;
    got = {period_start, pending, pwm_sig};
    exp = exp_q.pop_front();
    check("cycle", 32'(got), 32'(exp));
    hi0  += int'(pwm_sig[0]);
    hi1  += int'(pwm_sig[1]);
    ps_n += int'(period_start);
  endtask

  // One full output period starting at counter 0, with up to two writes at
  // counter index a_at / b_at (-1 = none). Checks high counts per channel.
  task automatic run_period(input int e0, input int e1,
                            input int a_at, input logic [CH-1:0] a_mask, input int a_d0, input int a_d1,
                            input int b_at, input logic [CH-1:0] b_mask, input int b_d0, input int b_d1);
    hi0 = 0; hi1 = 0; ps_n = 0;
    for (int k = 0; k < PERIOD; k++) begin
      if (k == a_at) begin duty = {W'(a_d1), W'(a_d0)}; duty_wr = a_mask; end
      if (k == b_at) begin duty = {W'(b_d1), W'(b_d0)}; duty_wr = b_mask; end
      step();
      if (k == 0) check("rise", 32'({period_start, pwm_sig}), 32'({1'b1, e1 != 0, e0 != 0}));
      if (k == a_at) check("pend_set", 32'(pending & a_mask), 32'(a_mask));
    end
    check("hi0", hi0, e0);
    check("hi1", hi1, e1);
    check("ps_per_period", ps_n, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    en      = 1'b0;
    duty    = '0;
    duty_wr = '0;
    model_reset();

    // Writes during reset must be ignored and outputs stay low.
    for (int k = 0; k < 4; k++) begin
      duty    = 16'($urandom);
      duty_wr = 2'b11;
      en      = k[0];
      @(posedge clk);
      #1;
      check("rst_out", 32'({period_start, pending, pwm_sig}), 32'd0);
    end
    duty_wr = '0;
    en      = 1'b0;
    rst_n   = 1'b1;

`ifdef PWM_CENTER_EN
    duty = {8'd0, 8'd100}; duty_wr = 2'b11;
    step();
    step();
    en = 1'b1;
    run_period(199, 0, -1, 2'b00, 0, 0, -1, 2'b00, 0, 0);
    run_period(199, 0, -1, 2'b00, 0, 0, -1, 2'b00, 0, 0);
`else
    // Program both channels while disabled, then enable.
    duty = {8'd128, 8'd32}; duty_wr = 2'b11;
    step();
    check("pend_idle", 32'(pending), 32'h3);
    step();
    check("xfer_idle", 32'(pending), 32'h0);
    en = 1'b1;
    run_period(32, 128, -1, 2'b00, 0, 0, -1, 2'b00, 0, 0);
    // Mid-period write only takes effect next period.
    run_period(32, 128, 100, 2'b01, 64, 0, -1, 2'b00, 0, 0);
    run_period(64, 128, 50, 2'b01, 32, 0, -1, 2'b00, 0, 0);
    // Write coincident with the wrap: 48 transfers, 96 stays pending.
    run_period(32, 128, 200, 2'b01, 48, 0, 255, 2'b01, 96, 0);
    check("pend_coinc", 32'(pending[0]), 32'd1);
    run_period(48, 128, -1, 2'b00, 0, 0, -1, 2'b00, 0, 0);
    check("pend_clear", 32'(pending[0]), 32'd0);
    // Boundary duties.
    run_period(96, 128, 10, 2'b11, 0, 255, -1, 2'b00, 0, 0);
    run_period(0, 255, -1, 2'b00, 0, 0, -1, 2'b00, 0, 0);

    // Asynchronous reset mid-period at counter 77.
    for (int k = 0; k < 77; k++) step();
    check("pre_arst", 32'(pwm_sig), 32'h2);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst", 32'({period_start, pending, pwm_sig}), 32'd0);
    model_reset();
    for (int k = 0; k < 2; k++) begin
      @(posedge clk);
      #1;
      check("arst_hold", 32'({period_start, pending, pwm_sig}), 32'd0);
    end
    rst_n = 1'b1;
    run_period(0, 0, -1, 2'b00, 0, 0, -1, 2'b00, 0, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
